// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: dispenser state encoding and coin values.
package vend_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SELECT = 3'd1,
      EJECT  = 3'd2,
      GAP    = 3'd3,
      DONE   = 3'd4
   } disp_state_t;

   // Coin values in nickel units, also used by the vending FSM.
   localparam int COIN_N_UNITS = 1;
   localparam int COIN_D_UNITS = 2;

endpackage

// File: rtl/disp_timer.sv
// Loadable down-counter with zero flag.
// Times both the inter-coin gap and the hopper-ack timeout.
module disp_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_r;

   // Load has priority; decrement parks at zero instead of wrapping.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_r <= {W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (dec && (cnt_r != {W{1'b0}})) begin
         cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/coin_change_dispenser.sv
// Change-return engine: pays out an amount (nickel units) greedily as dimes
// then nickels, handshaking each coin with the hopper and tracking inventory.
module coin_change_dispenser
   import vend_pkg::*;
#(
   parameter int AMT_W      = 4,
   parameter int INV_W      = 6,
   parameter int INIT_DIMES = 8,
   parameter int INIT_NICKS = 8,
   parameter int GAP_CYC    = 2,
   parameter int ACK_TO     = 15
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [AMT_W-1:0] amount,
   input  logic             refill_d,
   input  logic             refill_n,
   input  logic             hopper_ack,
   output logic             D,
   output logic             N,
   output logic             busy,
   output logic             done,
   output logic             short_o,
   output logic             fault,
   output logic [AMT_W-1:0] rem,
   output logic [INV_W-1:0] dime_cnt,
   output logic [INV_W-1:0] nick_cnt
);

   localparam int TMR_MAX = (ACK_TO > GAP_CYC) ? ACK_TO : GAP_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [AMT_W-1:0] D_UNITS  = AMT_W'(COIN_D_UNITS);
   localparam logic [AMT_W-1:0] N_UNITS  = AMT_W'(COIN_N_UNITS);
   localparam logic [INV_W-1:0] INV_MAX  = {INV_W{1'b1}};
   localparam logic [INV_W-1:0] INV_ZERO = {INV_W{1'b0}};
   localparam logic [INV_W-1:0] INV_ONE  = INV_W'(1);

   disp_state_t      state_r;
   logic             pick_d_s;
   logic             pick_n_s;
   logic             take_d_s;
   logic             take_n_s;
   logic             tmr_load_s;
   logic [TMR_W-1:0] tmr_val_s;
   logic             tmr_dec_s;
   logic             tmr_zero_s;

   // Next inventory value: refill and take in the same cycle cancel out,
   // refills saturate at full scale.
   function automatic logic [INV_W-1:0] inv_next(input logic [INV_W-1:0] cnt,
                                                 input logic inc,
                                                 input logic dec);
      logic [INV_W-1:0] nxt;
      if (inc && !dec) begin
         nxt = (cnt == INV_MAX) ? cnt : cnt + INV_ONE;
      end else if (dec && !inc) begin
         nxt = cnt - INV_ONE;
      end else begin
         nxt = cnt;
      end
      return nxt;
   endfunction

   // Greedy coin choice and acknowledged-coin strobes.
   always_comb begin
      pick_d_s = (rem >= D_UNITS) && (dime_cnt != INV_ZERO);
      pick_n_s = !pick_d_s && (rem >= N_UNITS) && (nick_cnt != INV_ZERO);
      take_d_s = (state_r == EJECT) && hopper_ack && D;
      take_n_s = (state_r == EJECT) && hopper_ack && N;
   end

   // Timer control: arm ack timeout on request, arm gap on ack, count otherwise.
   always_comb begin
      tmr_load_s = 1'b0;
      tmr_val_s  = {TMR_W{1'b0}};
      tmr_dec_s  = 1'b0;
      case (state_r)
         SELECT: begin
            if (pick_d_s || pick_n_s) begin
               tmr_load_s = 1'b1;
               tmr_val_s  = TMR_W'(ACK_TO - 1);
            end else begin
               tmr_load_s = 1'b0;
            end
         end
         EJECT: begin
            if (hopper_ack) begin
               tmr_load_s = 1'b1;
               tmr_val_s  = TMR_W'(GAP_CYC - 1);
            end else begin
               tmr_dec_s = 1'b1;
            end
         end
         GAP:     tmr_dec_s = 1'b1;
         default: tmr_dec_s = 1'b0;
      endcase
   end

   disp_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rstn     (rstn),
      .load     (tmr_load_s),
      .load_val (tmr_val_s),
      .dec      (tmr_dec_s),
      .zero     (tmr_zero_s)
   );

   // Transaction sequencer: coin selection, hopper handshake and status flags.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= IDLE;
         D       <= 1'b0;
         N       <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         short_o <= 1'b0;
         fault   <= 1'b0;
         rem     <= {AMT_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  rem     <= amount;
                  short_o <= 1'b0;
                  fault   <= 1'b0;
                  busy    <= 1'b1;
                  state_r <= SELECT;
               end
            end
            SELECT: begin
               if (pick_d_s) begin
                  D       <= 1'b1;
                  state_r <= EJECT;
               end else if (pick_n_s) begin
                  N       <= 1'b1;
                  state_r <= EJECT;
               end else begin
                  short_o <= (rem != {AMT_W{1'b0}});
                  done    <= 1'b1;
                  state_r <= DONE;
               end
            end
            EJECT: begin
               if (hopper_ack) begin
                  D       <= 1'b0;
                  N       <= 1'b0;
                  rem     <= D ? (rem - D_UNITS) : (rem - N_UNITS);
                  state_r <= GAP;
               end else if (tmr_zero_s) begin
                  D       <= 1'b0;
                  N       <= 1'b0;
                  fault   <= 1'b1;
                  done    <= 1'b1;
                  state_r <= DONE;
               end
            end
            GAP: begin
               if (tmr_zero_s) begin
                  state_r <= SELECT;
               end
            end
            DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               D       <= 1'b0;
               N       <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Inventory counters: refills accepted in every state, takes on coin ack.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dime_cnt <= INV_W'(INIT_DIMES);
         nick_cnt <= INV_W'(INIT_NICKS);
      end else begin
         dime_cnt <= inv_next(dime_cnt, refill_d, take_d_s);
         nick_cnt <= inv_next(nick_cnt, refill_n, take_n_s);
      end
   end

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Scoreboard bench for coin_change_dispenser: a change-making model predicts
// the coin sequence and final status of each transaction; a monitor compares
// every coin request and done pulse against the queued predictions.
module tb_coin_change_dispenser;
   import vend_pkg::*;

   localparam int ACK_TO  = 15;
   localparam int INIT_D  = 8;
   localparam int INIT_N  = 8;
   localparam int INV_MAX = 63;

   logic       clk = 1'b0;
   logic       rstn, start, refill_d, refill_n_stim, refill_n_ack, hopper_ack;
   logic       refill_n;
   logic [3:0] amount;
   logic       D, N, busy, done, short_o, fault;
   logic [3:0] rem;
   logic [5:0] dime_cnt, nick_cnt;

   assign refill_n = refill_n_stim | refill_n_ack;

   coin_change_dispenser dut (
      .clk(clk), .rstn(rstn), .start(start), .amount(amount),
      .refill_d(refill_d), .refill_n(refill_n), .hopper_ack(hopper_ack),
      .D(D), .N(N), .busy(busy), .done(done), .short_o(short_o), .fault(fault),
      .rem(rem), .dime_cnt(dime_cnt), .nick_cnt(nick_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int rem;
      bit short_f;
      bit fault_f;
      int dimes;
      int nicks;
   } done_rec_t;

   done_rec_t done_q[$];
   bit        coin_q[$];   // 1 = dime, 0 = nickel
   int        mdimes, mnicks;
   int        n_pass = 0, n_total = 0;
   bit        ack_en = 1'b1;
   int        ack_dly = 1;
   bit        ack_refill_n = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic int sat_inc(input int v);
      return (v >= INV_MAX) ? v : v + 1;
   endfunction

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Reference: greedy change-making from current inventory; without hopper
   // acks, the first coin requested times out and nothing is paid.
   task automatic expect_txn(input int amt);
      done_rec_t r;
      int du, nu, left;
      r.fault_f = 1'b0;
      r.short_f = 1'b0;
      if (!ack_en) begin
         r.rem = amt;
         if (amt >= COIN_D_UNITS && mdimes > 0) begin
            coin_q.push_back(1'b1);
            r.fault_f = 1'b1;
         end else if (amt >= COIN_N_UNITS && mnicks > 0) begin
            coin_q.push_back(1'b0);
            r.fault_f = 1'b1;
         end else begin
            r.short_f = (amt != 0);
         end
      end else begin
         du   = imin(mdimes, amt / COIN_D_UNITS);
         left = amt - du * COIN_D_UNITS;
         nu   = imin(mnicks, left);
         left = left - nu;
         for (int i = 0; i < du; i++) coin_q.push_back(1'b1);
         for (int i = 0; i < nu; i++) coin_q.push_back(1'b0);
         mdimes    = mdimes - du;
         mnicks    = mnicks - nu;
         r.rem     = left;
         r.short_f = (left != 0);
      end
      r.dimes = mdimes;
      r.nicks = mnicks;
      done_q.push_back(r);
   endtask

   task automatic drive_start(input int amt);
      start  = 1'b1;
      amount = 4'(amt);
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 600 && !done; i++) @(negedge clk);
      check("done_seen", int'(done), 1);
      @(negedge clk);
   endtask

   task automatic run_txn(input int amt);
      expect_txn(amt);
      drive_start(amt);
      wait_done();
   endtask

   task automatic pulse_refill(input bit dime);
      if (dime) begin
         refill_d = 1'b1;
         mdimes   = sat_inc(mdimes);
      end else begin
         refill_n_stim = 1'b1;
         mnicks        = sat_inc(mnicks);
      end
      @(negedge clk);
      refill_d      = 1'b0;
      refill_n_stim = 1'b0;
   endtask

   task automatic wait_coin();
      for (int i = 0; i < 50 && !(D || N); i++) @(negedge clk);
      check("coin_seen", int'(D || N), 1);
   endtask

   // Hopper model: acknowledges each request after ack_dly cycles.
   initial begin
      hopper_ack   = 1'b0;
      refill_n_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (rstn && (D || N) && ack_en && !hopper_ack) begin
            repeat (ack_dly) @(negedge clk);
            hopper_ack   = 1'b1;
            refill_n_ack = ack_refill_n;
            @(negedge clk);
            hopper_ack   = 1'b0;
            refill_n_ack = 1'b0;
            ack_refill_n = 1'b0;
         end
      end
   end

   // Monitor: pops and compares on each new coin request and each done pulse.
   initial begin
      bit        pd, pn, exp_d;
      done_rec_t r;
      pd = 1'b0;
      pn = 1'b0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            pd = 1'b0;
            pn = 1'b0;
         end else begin
            if ((D && !pd) || (N && !pn)) begin
               check("coin_exclusive", int'(D && N), 0);
               check("coin_expected", int'(coin_q.size() > 0), 1);
               if (coin_q.size() > 0) begin
                  exp_d = coin_q.pop_front();
                  check("coin_is_dime", int'(D), int'(exp_d));
               end
            end
            if (done) begin
               check("done_expected", int'(done_q.size() > 0), 1);
               if (done_q.size() > 0) begin
                  r = done_q.pop_front();
                  check("done_rem", int'(rem), r.rem);
                  check("done_short", int'(short_o), int'(r.short_f));
                  check("done_fault", int'(fault), int'(r.fault_f));
                  check("done_dimes", int'(dime_cnt), r.dimes);
                  check("done_nicks", int'(nick_cnt), r.nicks);
                  check("done_busy", int'(busy), 1);
               end
            end
            pd = D;
            pn = N;
         end
      end
   end

   initial begin
      int hold, amt, nd, nn;
      rstn = 1'b1; start = 1'b0; amount = 4'd0; refill_d = 1'b0; refill_n_stim = 1'b0;
      #2 rstn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_D", int'(D), 0);
      check("rst_N", int'(N), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_short", int'(short_o), 0);
      check("rst_fault", int'(fault), 0);
      check("rst_rem", int'(rem), 0);
      check("rst_dimes", int'(dime_cnt), INIT_D);
      check("rst_nicks", int'(nick_cnt), INIT_N);
      rstn   = 1'b1;
      mdimes = INIT_D;
      mnicks = INIT_N;
      @(negedge clk);

      // Bring inventory to 1 dime / 5 nickels.
      run_txn(14);
      for (int i = 0; i < 3; i++) run_txn(1);

      // Case 1: amount 3 -> dime then nickel; start in cycle 0, D in cycle 2.
      expect_txn(3);
      start = 1'b1; amount = 4'd3;
      @(posedge clk); #1 start = 1'b0;
      check("t1_D_low_cycle1", int'(D), 0);
      check("t1_busy", int'(busy), 1);
      @(posedge clk); #1;
      check("t1_D_high_cycle2", int'(D), 1);
      wait_done();
      check("t1_dimes", int'(dime_cnt), 0);
      check("t1_nicks", int'(nick_cnt), 4);

      // Case 2: 1 nickel left, amount 4 -> short with rem 3.
      run_txn(3);
      run_txn(4);
      check("t2_short", int'(short_o), 1);
      check("t2_rem", int'(rem), 3);
      check("t2_nicks", int'(nick_cnt), 0);

      // Case 3: no ack -> D held exactly ACK_TO cycles, fault.
      pulse_refill(1'b1);
      pulse_refill(1'b1);
      ack_en = 1'b0;
      expect_txn(2);
      drive_start(2);
      wait_coin();
      hold = 0;
      while (D && hold < 100) begin
         hold++;
         @(negedge clk);
      end
      check("t3_D_hold", hold, ACK_TO);
      wait_done();
      check("t3_fault", int'(fault), 1);
      check("t3_rem", int'(rem), 2);
      check("t3_dimes", int'(dime_cnt), 2);
      ack_en = 1'b1;

      // Case 4: amount 0 -> done in cycle 2, no coin.
      expect_txn(0);
      start = 1'b1; amount = 4'd0;
      @(posedge clk); #1 start = 1'b0;
      check("t4_done_cycle1", int'(done), 0);
      @(posedge clk); #1;
      check("t4_done_cycle2", int'(done), 1);
      check("t4_no_coin", int'(D || N), 0);
      wait_done();
      // 6-unit run with a stray start (amount 15) while busy.
      for (int i = 0; i < 6; i++) pulse_refill(1'b0);
      expect_txn(6);
      drive_start(6);
      drive_start(15);
      wait_done();
      check("t4_rem", int'(rem), 0);

      // Case 5: refill_n with the nickel ack at 3 nickels; dime saturation.
      run_txn(1);
      check("t5_nicks_before", int'(nick_cnt), 3);
      ack_refill_n = 1'b1;
      mnicks = sat_inc(mnicks);
      expect_txn(1);
      drive_start(1);
      wait_done();
      check("t5_nicks_after", int'(nick_cnt), 3);
      for (int i = 0; i < 64; i++) pulse_refill(1'b1);
      check("t5_dime_sat", int'(dime_cnt), 63);
      pulse_refill(1'b1);
      check("t5_dime_sat_again", int'(dime_cnt), 63);

      // Case 6: reset while D is high, then a normal nickel eject.
      ack_en = 1'b0;
      expect_txn(2);
      drive_start(2);
      wait_coin();
      rstn = 1'b0;
      #1;
      check("t6_D_drop", int'(D), 0);
      check("t6_busy", int'(busy), 0);
      check("t6_dimes", int'(dime_cnt), INIT_D);
      check("t6_nicks", int'(nick_cnt), INIT_N);
      coin_q.delete();
      done_q.delete();
      mdimes = INIT_D;
      mnicks = INIT_N;
      @(negedge clk);
      rstn   = 1'b1;
      ack_en = 1'b1;
      @(negedge clk);
      run_txn(1);
      check("t6_rem", int'(rem), 0);

      // Randomized transactions.
      for (int t = 0; t < 25; t++) begin
         nd = $urandom_range(0, 3);
         nn = $urandom_range(0, 3);
         for (int i = 0; i < nd; i++) pulse_refill(1'b1);
         for (int i = 0; i < nn; i++) pulse_refill(1'b0);
         ack_en  = ($urandom_range(0, 7) != 0);
         ack_dly = $urandom_range(0, 3);
         amt     = $urandom_range(0, 15);
         expect_txn(amt);
         drive_start(amt);
         if ($urandom_range(0, 1) == 1) drive_start($urandom_range(0, 15));
         wait_done();
         check("rand_dimes", int'(dime_cnt), mdimes);
         check("rand_nicks", int'(nick_cnt), mnicks);
      end
      ack_en = 1'b1;
      repeat (3) @(negedge clk);
      check("coin_q_drained", coin_q.size(), 0);
      check("done_q_drained", done_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
